// File: rtl/led_pattern_seq_pkg.sv
// Shared mode and direction codes for the LED pattern sequencer.
// Values match the legacy include so existing register maps stay valid.
package led_pattern_seq_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SHL   = 2'd0;
  localparam mode_t MODE_SHR   = 2'd1;
  localparam mode_t MODE_PING  = 2'd2;
  localparam mode_t MODE_BLINK = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_pattern_seq_tick_prescaler.sv
// Divides incoming tick pulses; o_step_en is asserted combinationally on the
// tick that completes a group of TICKS_PER_STEP unpaused ticks.
module tick_prescaler #(
  parameter int TICKS_PER_STEP = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_clear,
  input  logic i_hold,
  output logic o_step_en
);

  localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick_live;

  assign w_tick_live = i_tick && !i_hold;
  assign o_step_en   = w_tick_live && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (w_tick_live) begin
      r_cnt <= o_step_en ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: prescales counter_flag ticks and steps a rotate,
// ping-pong or blink pattern onto led_out, with run-time mode selection.
module led_pattern_seq
  import led_pattern_seq_pkg::*;
#(
  parameter int LED_W          = 4,
  parameter int TICKS_PER_STEP = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tick_in,
  input  logic [1:0]       mode_in,
  input  logic             mode_valid,
  input  logic             pause,
  output logic [LED_W-1:0] led_out,
  output logic             wrap_flag
);

  logic [LED_W-1:0] r_led;
  mode_t            r_mode;
  logic             r_dir;
  logic             r_wrap;

  logic             w_mode_chg;
  logic             w_step;
  logic [LED_W-1:0] w_start;
  logic [LED_W-1:0] w_next;
  logic             w_next_dir;
  logic             w_wrap;

  assign w_mode_chg = mode_valid && (mode_in != r_mode);

  tick_prescaler #(
    .TICKS_PER_STEP (TICKS_PER_STEP)
  ) u_prescaler (
    .i_clk     (sys_clk),
    .i_rst_n   (sys_rst_n),
    .i_tick    (tick_in),
    .i_clear   (w_mode_chg),
    .i_hold    (pause),
    .o_step_en (w_step)
  );

  always_comb begin
    w_start = '0;
    case (mode_in)
      MODE_SHR:   w_start[LED_W-1] = 1'b1;
      MODE_BLINK: w_start = '1;
      default:    w_start[0] = 1'b1;
    endcase
  end

  // Ping-pong flips direction on the step that lands on an end bit, so the
  // landing test looks at the bit adjacent to the end before the shift.
  always_comb begin
    w_next     = r_led;
    w_next_dir = r_dir;
    w_wrap     = 1'b0;
    case (r_mode)
      MODE_SHL: begin
        w_next = {r_led[LED_W-2:0], r_led[LED_W-1]};
        w_wrap = r_led[LED_W-1];
      end
      MODE_SHR: begin
        w_next = {r_led[0], r_led[LED_W-1:1]};
        w_wrap = r_led[0];
      end
      MODE_PING: begin
        if (r_dir == DIR_UP) begin
          w_next = r_led << 1;
          if (r_led[LED_W-2]) w_next_dir = DIR_DOWN;
        end else begin
          w_next = r_led >> 1;
          if (r_led[1]) begin
            w_next_dir = DIR_UP;
            w_wrap     = 1'b1;
          end
        end
      end
      default: begin
        w_next = ~r_led;
        w_wrap = (r_led == '0);
      end
    endcase
  end

  // A mode change wins over a coincident step; that step is discarded.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_led    <= '0;
      r_led[0] <= 1'b1;
      r_mode   <= MODE_SHL;
      r_dir    <= DIR_UP;
      r_wrap   <= 1'b0;
    end else if (w_mode_chg) begin
      r_led  <= w_start;
      r_mode <= mode_in;
      r_dir  <= DIR_UP;
      r_wrap <= 1'b0;
    end else if (w_step) begin
      r_led  <= w_next;
      r_dir  <= w_next_dir;
      r_wrap <= w_wrap;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign led_out   = r_led;
  assign wrap_flag = r_wrap;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: two instances (TICKS_PER_STEP 2 and 1) share one
// stimulus stream; a position-based reference model tracks both.
module tb_led_pattern_seq;

  localparam int W = 4;

  logic         sys_clk;
  logic         sys_rst_n;
  logic         tick_in;
  logic [1:0]   mode_in;
  logic         mode_valid;
  logic         pause;
  logic [W-1:0] led_a, led_b;
  logic         wrap_a, wrap_b;

  int n_checks;
  int n_fail;

  // Model: each mode is a cyclic sequence of positions; wrap when position returns to 0.
  int m_mode [2];
  int m_pos  [2];
  int m_cnt  [2];
  bit m_wrap [2];
  int tps    [2];

  led_pattern_seq #(.LED_W(W), .TICKS_PER_STEP(2)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tick_in(tick_in), .mode_in(mode_in),
    .mode_valid(mode_valid), .pause(pause), .led_out(led_a), .wrap_flag(wrap_a));

  led_pattern_seq #(.LED_W(W), .TICKS_PER_STEP(1)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tick_in(tick_in), .mode_in(mode_in),
    .mode_valid(mode_valid), .pause(pause), .led_out(led_b), .wrap_flag(wrap_b));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic int period(input int mode);
    case (mode)
      0, 1:    return W;
      2:       return 2 * W - 2;
      default: return 2;
    endcase
  endfunction

  function automatic logic [W-1:0] model_led(input int mode, input int pos);
    logic [W-1:0] one;
    one = 1;
    case (mode)
      0:       return one << pos;
      1:       return one << (W - 1 - pos);
      2:       return (pos < W) ? (one << pos) : (one << (2 * W - 2 - pos));
      default: return (pos == 0) ? '1 : '0;
    endcase
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (!sys_rst_n) begin
        m_mode[i] = 0; m_pos[i] = 0; m_cnt[i] = 0; m_wrap[i] = 0;
      end else if (mode_valid && int'(mode_in) != m_mode[i]) begin
        m_mode[i] = int'(mode_in); m_pos[i] = 0; m_cnt[i] = 0; m_wrap[i] = 0;
      end else if (tick_in && !pause) begin
        if (m_cnt[i] == tps[i] - 1) begin
          m_cnt[i]  = 0;
          m_pos[i]  = (m_pos[i] + 1) % period(m_mode[i]);
          m_wrap[i] = (m_pos[i] == 0);
        end else begin
          m_cnt[i]  = m_cnt[i] + 1;
          m_wrap[i] = 0;
        end
      end else begin
        m_wrap[i] = 0;
      end
    end
  endtask

  task automatic step_clk();
    @(posedge sys_clk);
    model_update();
    #1;
  endtask

  // Four idle cycles, then one cycle carrying the given tick / mode request.
  task automatic pulse(input bit tk, input bit mv, input logic [1:0] mi);
    repeat (4) step_clk();
    tick_in = tk; mode_valid = mv; mode_in = mi;
    step_clk();
    tick_in = 1'b0; mode_valid = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; tick_in = 1'b0; mode_valid = 1'b0; mode_in = 2'd0; pause = 1'b0;
    step_clk(); step_clk();
    n_checks++; if (led_a !== 4'h1) begin n_fail++; $display("FAIL reset_led_a got=%h exp=1", led_a); end
    n_checks++; if (led_b !== 4'h1) begin n_fail++; $display("FAIL reset_led_b got=%h exp=1", led_b); end
    n_checks++; if (wrap_a !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_a got=%b exp=0", wrap_a); end
    n_checks++; if (wrap_b !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_b got=%b exp=0", wrap_b); end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_shl();
    logic [W-1:0] exp_led [8] = '{4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1};
    for (int k = 0; k < 8; k++) begin
      pulse(1'b1, 1'b0, 2'd0);
      n_checks++; if (led_a !== exp_led[k]) begin n_fail++; $display("FAIL shl_led tick=%0d got=%h exp=%h", k, led_a, exp_led[k]); end
      n_checks++; if (wrap_a !== (k == 7)) begin n_fail++; $display("FAIL shl_wrap tick=%0d got=%b exp=%b", k, wrap_a, k == 7); end
    end
    step_clk();
    n_checks++; if (wrap_a !== 1'b0) begin n_fail++; $display("FAIL shl_wrap_len got=%b exp=0", wrap_a); end
  endtask

  task automatic test_ping();
    logic [W-1:0] exp_led [8] = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};
    pulse(1'b0, 1'b1, 2'd2);
    n_checks++; if (led_b !== 4'h1) begin n_fail++; $display("FAIL ping_reload got=%h exp=1", led_b); end
    for (int k = 0; k < 8; k++) begin
      pulse(1'b1, 1'b0, 2'd0);
      n_checks++; if (led_b !== exp_led[k]) begin n_fail++; $display("FAIL ping_led tick=%0d got=%h exp=%h", k, led_b, exp_led[k]); end
      n_checks++; if (wrap_b !== (k == 5)) begin n_fail++; $display("FAIL ping_wrap tick=%0d got=%b exp=%b", k, wrap_b, k == 5); end
    end
  endtask

  task automatic test_pause();
    pulse(1'b0, 1'b1, 2'd1);
    n_checks++; if (led_a !== 4'h8) begin n_fail++; $display("FAIL shr_reload got=%h exp=8", led_a); end
    pulse(1'b1, 1'b0, 2'd0);
    pulse(1'b1, 1'b0, 2'd0);
    n_checks++; if (led_a !== 4'h4) begin n_fail++; $display("FAIL shr_step got=%h exp=4", led_a); end
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pulse(1'b1, 1'b0, 2'd0);
      n_checks++; if (led_a !== 4'h4) begin n_fail++; $display("FAIL pause_hold_a k=%0d got=%h exp=4", k, led_a); end
      n_checks++; if (led_b !== 4'h2) begin n_fail++; $display("FAIL pause_hold_b k=%0d got=%h exp=2", k, led_b); end
    end
    pause = 1'b0;
    pulse(1'b1, 1'b0, 2'd0);
    n_checks++; if (led_a !== 4'h4) begin n_fail++; $display("FAIL pause_cnt_held got=%h exp=4", led_a); end
    pulse(1'b1, 1'b0, 2'd0);
    n_checks++; if (led_a !== 4'h2) begin n_fail++; $display("FAIL pause_release got=%h exp=2", led_a); end
  endtask

  task automatic test_mode_priority();
    pulse(1'b1, 1'b0, 2'd0);
    pulse(1'b1, 1'b1, 2'd3);
    n_checks++; if (led_a !== 4'hF) begin n_fail++; $display("FAIL prio_blink got=%h exp=f", led_a); end
    n_checks++; if (wrap_a !== 1'b0) begin n_fail++; $display("FAIL prio_wrap got=%b exp=0", wrap_a); end
    pulse(1'b1, 1'b0, 2'd0);
    n_checks++; if (led_a !== 4'hF) begin n_fail++; $display("FAIL blink_hold got=%h exp=f", led_a); end
    pulse(1'b1, 1'b0, 2'd0);
    n_checks++; if (led_a !== 4'h0) begin n_fail++; $display("FAIL blink_off got=%h exp=0", led_a); end
    n_checks++; if (wrap_a !== 1'b0) begin n_fail++; $display("FAIL blink_off_wrap got=%b exp=0", wrap_a); end
    pulse(1'b1, 1'b0, 2'd0);
    pulse(1'b1, 1'b0, 2'd0);
    n_checks++; if (led_a !== 4'hF) begin n_fail++; $display("FAIL blink_on got=%h exp=f", led_a); end
    n_checks++; if (wrap_a !== 1'b1) begin n_fail++; $display("FAIL blink_on_wrap got=%b exp=1", wrap_a); end
  endtask

  task automatic test_reset_mid();
    pulse(1'b0, 1'b1, 2'd2);
    for (int k = 0; k < 6; k++) pulse(1'b1, 1'b0, 2'd0);
    n_checks++; if (led_a !== 4'h8) begin n_fail++; $display("FAIL rstmid_pre got=%h exp=8", led_a); end
    sys_rst_n = 1'b0;
    step_clk();
    sys_rst_n = 1'b1;
    n_checks++; if (led_a !== 4'h1) begin n_fail++; $display("FAIL rstmid_led got=%h exp=1", led_a); end
    n_checks++; if (wrap_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_wrap got=%b exp=0", wrap_a); end
    for (int k = 0; k < 8; k++) pulse(1'b1, 1'b0, 2'd0);
    n_checks++; if (led_a !== 4'h1) begin n_fail++; $display("FAIL rstmid_shl got=%h exp=1", led_a); end
    n_checks++; if (wrap_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_shl_wrap got=%b exp=1", wrap_a); end
  endtask

  task automatic test_same_mode();
    pulse(1'b1, 1'b0, 2'd0);
    pulse(1'b1, 1'b0, 2'd0);
    pulse(1'b1, 1'b0, 2'd0);
    n_checks++; if (led_a !== 4'h2) begin n_fail++; $display("FAIL same_pre got=%h exp=2", led_a); end
    pulse(1'b0, 1'b1, 2'd0);
    n_checks++; if (led_a !== 4'h2) begin n_fail++; $display("FAIL same_noreload got=%h exp=2", led_a); end
    pulse(1'b1, 1'b0, 2'd0);
    n_checks++; if (led_a !== 4'h4) begin n_fail++; $display("FAIL same_step got=%h exp=4", led_a); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      tick_in    = ($urandom_range(0, 3) == 0);
      pause      = ($urandom_range(0, 4) == 0);
      mode_valid = ($urandom_range(0, 15) == 0);
      mode_in    = 2'($urandom_range(0, 3));
      sys_rst_n  = ($urandom_range(0, 199) != 0);
      step_clk();
      n_checks++; if (led_a !== model_led(m_mode[0], m_pos[0])) begin n_fail++; $display("FAIL rand_led_a cyc=%0d got=%h exp=%h", c, led_a, model_led(m_mode[0], m_pos[0])); end
      n_checks++; if (wrap_a !== m_wrap[0]) begin n_fail++; $display("FAIL rand_wrap_a cyc=%0d got=%b exp=%b", c, wrap_a, m_wrap[0]); end
      n_checks++; if (led_b !== model_led(m_mode[1], m_pos[1])) begin n_fail++; $display("FAIL rand_led_b cyc=%0d got=%h exp=%h", c, led_b, model_led(m_mode[1], m_pos[1])); end
      n_checks++; if (wrap_b !== m_wrap[1]) begin n_fail++; $display("FAIL rand_wrap_b cyc=%0d got=%b exp=%b", c, wrap_b, m_wrap[1]); end
    end
    tick_in = 1'b0; pause = 1'b0; mode_valid = 1'b0; sys_rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tps[0] = 2;
    tps[1] = 1;
    test_reset();
    test_shl();
    test_ping();
    test_pause();
    test_mode_priority();
    test_reset_mid();
    test_same_mode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
